// File: rtl/comp_pkg.sv
// Shared types and helpers for the pipelined magnitude comparator.
package comp_pkg;

   typedef enum logic [1:0] {
      CMP_UNSIGNED = 2'b00,
      CMP_SIGNED   = 2'b01,
      CMP_FLOAT    = 2'b10,
      CMP_RSVD     = 2'b11
   } comp_mode_e;

   typedef struct packed {
      logic less;
      logic equal;
   } comp_res_t;

   // Number of tree levels (leaf level included) for an operand width.
   function automatic int unsigned comp_levels(input int unsigned width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/comp_merge_node.sv
// Combinational merge of two adjacent compare results; hi covers the more significant bits.
module comp_merge_node
   import comp_pkg::*;
(
   input  comp_res_t hi_i,
   input  comp_res_t lo_i,
   output comp_res_t res_o
);

   always_comb begin
      res_o.less  = hi_i.less | (hi_i.equal & lo_i.less);
      res_o.equal = hi_i.equal & lo_i.equal;
   end

endmodule

// File: rtl/comp_pipe_nbit.sv
// Pipelined WIDTH-bit magnitude comparator (unsigned / signed / sign-magnitude float).
// Define COMP_FP_NAN_EN to flag NaN operands in float mode as unordered.
module comp_pipe_nbit
   import comp_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data_a,
   input  logic [WIDTH-1:0] i_data_b,
   input  logic [1:0]       i_mode,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_less,
   output logic             o_equal,
   output logic             o_greater,
   output logic             o_unordered,
   output logic [TAG_W-1:0] o_tag
);

   localparam int unsigned LEVELS = comp_levels(WIDTH);
   localparam int unsigned LEAVES = WIDTH / 2;
   localparam int unsigned LAST   = LEVELS - 2;
   localparam int unsigned MAG_W  = EXP_W + MAN_W;
   localparam int unsigned TQ_N   = (LEAVES > 2) ? LEAVES - 2 : 1;
   localparam int          TQ_USE = int'(LEAVES) - 2;
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   // Maps each ordering onto plain unsigned order of the transformed pattern.
   function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] v, input comp_mode_e m);
      logic [WIDTH-1:0] r;
      r = v;
      case (m)
         CMP_SIGNED: r = v ^ MSB_MASK;
         CMP_FLOAT:  r = v[WIDTH-1] ? ~v : (v ^ MSB_MASK);
         default:    r = v;
      endcase
      return r;
   endfunction

   logic en;
   assign en      = i_ready | ~o_valid;
   assign o_ready = en;

   comp_mode_e       mode;
   logic [WIDTH-1:0] a_t, b_t;
   logic             both_zero;
   comp_res_t        leaf_d [LEAVES];
   comp_res_t        leaf_q [LEAVES];

   always_comb begin
      mode      = comp_mode_e'(i_mode);
      a_t       = xform(i_data_a, mode);
      b_t       = xform(i_data_b, mode);
      both_zero = (mode == CMP_FLOAT) && (i_data_a[MAG_W-1:0] == '0)
                  && (i_data_b[MAG_W-1:0] == '0);
      for (int i = 0; i < int'(LEAVES); i++) begin
         leaf_d[i].less  = a_t[2*i +: 2] < b_t[2*i +: 2];
         leaf_d[i].equal = a_t[2*i +: 2] == b_t[2*i +: 2];
      end
   end

`ifdef COMP_FP_NAN_EN
   logic a_nan, b_nan, any_nan;
   logic nan_q [LEVELS-1];
   always_comb begin
      a_nan   = (&i_data_a[MAG_W-1:MAN_W]) & (|i_data_a[MAN_W-1:0]);
      b_nan   = (&i_data_b[MAG_W-1:MAN_W]) & (|i_data_b[MAN_W-1:0]);
      any_nan = (mode == CMP_FLOAT) & (a_nan | b_nan);
   end
`endif

   // Sideband pipeline: valid, tag and zero/NaN flags move with the tree levels.
   logic             vld_q  [LEVELS-1];
   logic [TAG_W-1:0] tag_q  [LEVELS-1];
   logic             zero_q [LEVELS-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int s = 0; s < int'(LEVELS) - 1; s++) begin
            vld_q[s]  <= 1'b0;
            tag_q[s]  <= '0;
            zero_q[s] <= 1'b0;
`ifdef COMP_FP_NAN_EN
            nan_q[s]  <= 1'b0;
`endif
         end
      end else if (en) begin
         vld_q[0]  <= i_valid;
         tag_q[0]  <= i_tag;
         zero_q[0] <= both_zero;
`ifdef COMP_FP_NAN_EN
         nan_q[0]  <= any_nan;
`endif
         for (int s = 1; s < int'(LEVELS) - 1; s++) begin
            vld_q[s]  <= vld_q[s-1];
            tag_q[s]  <= tag_q[s-1];
            zero_q[s] <= zero_q[s-1];
`ifdef COMP_FP_NAN_EN
            nan_q[s]  <= nan_q[s-1];
`endif
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (en) leaf_q <= leaf_d;
   end

   // Tree nodes above the leaves, stored level after level; the root is the last entry.
   comp_res_t tree_d [LEAVES-1];
   comp_res_t tree_q [TQ_N];

   for (genvar k = 1; k < int'(LEVELS); k++) begin : g_level
      localparam int unsigned N = WIDTH >> (k + 1);
      localparam int unsigned T = LEAVES - (WIDTH >> k);
      for (genvar j = 0; j < int'(N); j++) begin : g_node
         comp_res_t hi, lo;
         if (k == 1) begin : g_from_leaf
            assign hi = leaf_q[2*j+1];
            assign lo = leaf_q[2*j];
         end else begin : g_from_tree
            localparam int unsigned TP = LEAVES - (WIDTH >> (k - 1));
            assign hi = tree_q[TP+2*j+1];
            assign lo = tree_q[TP+2*j];
         end
         comp_merge_node u_node (
            .hi_i  (hi),
            .lo_i  (lo),
            .res_o (tree_d[T+j])
         );
      end
   end

   always_ff @(posedge i_clk) begin
      if (en) begin
         for (int i = 0; i < TQ_USE; i++) tree_q[i] <= tree_d[i];
      end
   end

   logic fin_less, fin_equal, fin_greater, fin_unord;

   always_comb begin
      fin_less  = tree_d[LEAVES-2].less;
      fin_equal = tree_d[LEAVES-2].equal;
      fin_unord = 1'b0;
      if (zero_q[LAST]) begin
         fin_less  = 1'b0;
         fin_equal = 1'b1;
      end
`ifdef COMP_FP_NAN_EN
      if (nan_q[LAST]) begin
         fin_less  = 1'b0;
         fin_equal = 1'b0;
         fin_unord = 1'b1;
      end
`endif
      fin_greater = ~fin_unord & ~fin_less & ~fin_equal;
   end

   // Result fields only load with a real result so they hold across bubbles.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid     <= 1'b0;
         o_less      <= 1'b0;
         o_equal     <= 1'b0;
         o_greater   <= 1'b0;
         o_tag       <= '0;
`ifdef COMP_FP_NAN_EN
         o_unordered <= 1'b0;
`endif
      end else if (en) begin
         o_valid <= vld_q[LAST];
         if (vld_q[LAST]) begin
            o_less      <= fin_less;
            o_equal     <= fin_equal;
            o_greater   <= fin_greater;
            o_tag       <= tag_q[LAST];
`ifdef COMP_FP_NAN_EN
            o_unordered <= fin_unord;
`endif
         end
      end
   end

`ifndef COMP_FP_NAN_EN
   assign o_unordered = 1'b0;
`endif

endmodule
